// File: rtl/forward_unit_pkg.sv
// Shared types for the operand forwarding unit: tracker slot, FSM state,
// operand source select, and the slot/source match rule.
package forward_unit_pkg;

    localparam int MAX_REG_AW = 8;

    typedef enum logic {
        RUN,
        STALL
    } fsm_state_e;

    typedef enum logic [1:0] {
        SRC_RF,
        SRC_EX,
        SRC_MEM,
        SRC_WB
    } src_sel_e;

    typedef struct packed {
        logic                  valid;
        logic [MAX_REG_AW-1:0] addr;
        logic                  memread;
    } slot_t;

    // Register 0 is hardwired, so a write to it never produces a forwardable value.
    function automatic logic slot_match(input logic valid,
                                        input logic [MAX_REG_AW-1:0] addr,
                                        input logic [MAX_REG_AW-1:0] src);
        return valid && (addr == src) && (src != '0);
    endfunction

endpackage

// File: rtl/forward_unit_select.sv
// Source select for one operand: EX > MEM > WB > register file.
// The WB slot is only eligible when FORWARD_WB_EN is defined.
module forward_select
    import forward_unit_pkg::*;
(
    input  logic [MAX_REG_AW-1:0]      src_addr,
    input  logic [2:0]                 slot_valid,
    input  logic [2:0][MAX_REG_AW-1:0] slot_addr,
    output src_sel_e                   sel
);

`ifdef FORWARD_WB_EN
    localparam bit WB_EN = 1'b1;
`else
    localparam bit WB_EN = 1'b0;
`endif

    logic hit_ex;
    logic hit_mem;
    logic hit_wb;

    assign hit_ex  = slot_match(slot_valid[0], slot_addr[0], src_addr);
    assign hit_mem = slot_match(slot_valid[1], slot_addr[1], src_addr);
    assign hit_wb  = slot_match(slot_valid[2], slot_addr[2], src_addr) && WB_EN;

    always_comb begin
        sel = SRC_RF;
        if (hit_ex)
            sel = SRC_EX;
        else if (hit_mem)
            sel = SRC_MEM;
        else if (hit_wb)
            sel = SRC_WB;
    end

endmodule

// File: rtl/forward_unit.sv
// Operand forwarding and load-use stall control for a 5-stage pipeline.
// Define FORWARD_WB_EN to allow forwarding from the WB slot.
module forward_unit
    import forward_unit_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int REG_AW = 5
)
(
    input  logic              CLOCK,
    input  logic              RESET,
    input  logic              Hold_IN,
    input  logic [REG_AW-1:0] RsAddr_IN,
    input  logic [REG_AW-1:0] RtAddr_IN,
    input  logic [DATA_W-1:0] RsData_IN,
    input  logic [DATA_W-1:0] RtData_IN,
    input  logic [REG_AW-1:0] WriteReg_IN,
    input  logic              RegWrite_IN,
    input  logic              MemRead_IN,
    input  logic [DATA_W-1:0] ALUResult_IN,
    input  logic [DATA_W-1:0] MEMResult_IN,
    input  logic [DATA_W-1:0] WBData_IN,
    output logic [DATA_W-1:0] FOperandA_OUT,
    output logic [DATA_W-1:0] FOperandB_OUT,
    output logic              Forward_OUT,
    output logic              Stall_OUT
);

    // state | meaning
    // RUN   | normal shift, operands captured for the ID instruction
    // STALL | one bubble was inserted; next un-held edge returns to RUN

    slot_t                 slot_ex;
    slot_t                 slot_mem;
    slot_t                 slot_wb;
    slot_t                 slot_id;
    fsm_state_e            state;
    src_sel_e              sel_a;
    src_sel_e              sel_b;
    logic [MAX_REG_AW-1:0] rs;
    logic [MAX_REG_AW-1:0] rt;
    logic [DATA_W-1:0]     op_a;
    logic [DATA_W-1:0]     op_b;
    logic                  stall_edge;
    logic                  unused_wb_memread;

    assign rs      = MAX_REG_AW'(RsAddr_IN);
    assign rt      = MAX_REG_AW'(RtAddr_IN);
    assign slot_id = '{valid: RegWrite_IN, addr: MAX_REG_AW'(WriteReg_IN), memread: MemRead_IN};
    assign unused_wb_memread = slot_wb.memread;

    assign Stall_OUT = slot_ex.memread &&
                       (slot_match(slot_ex.valid, slot_ex.addr, rs) ||
                        slot_match(slot_ex.valid, slot_ex.addr, rt));
    assign stall_edge = Stall_OUT && (state == RUN);

    forward_select u_sel_a (
        .src_addr   (rs),
        .slot_valid ({slot_wb.valid, slot_mem.valid, slot_ex.valid}),
        .slot_addr  ({slot_wb.addr, slot_mem.addr, slot_ex.addr}),
        .sel        (sel_a)
    );

    forward_select u_sel_b (
        .src_addr   (rt),
        .slot_valid ({slot_wb.valid, slot_mem.valid, slot_ex.valid}),
        .slot_addr  ({slot_wb.addr, slot_mem.addr, slot_ex.addr}),
        .sel        (sel_b)
    );

    always_comb begin
        op_a = RsData_IN;
        case (sel_a)
            SRC_EX:  op_a = ALUResult_IN;
            SRC_MEM: op_a = MEMResult_IN;
            SRC_WB:  op_a = WBData_IN;
            default: op_a = RsData_IN;
        endcase
    end

    always_comb begin
        op_b = RtData_IN;
        case (sel_b)
            SRC_EX:  op_b = ALUResult_IN;
            SRC_MEM: op_b = MEMResult_IN;
            SRC_WB:  op_b = WBData_IN;
            default: op_b = RtData_IN;
        endcase
    end

    always_ff @(posedge CLOCK or negedge RESET) begin
        if (!RESET) begin
            state         <= RUN;
            slot_ex       <= '0;
            slot_mem      <= '0;
            slot_wb       <= '0;
            FOperandA_OUT <= '0;
            FOperandB_OUT <= '0;
            Forward_OUT   <= 1'b0;
        end else if (!Hold_IN) begin
            slot_mem <= slot_ex;
            slot_wb  <= slot_mem;
            if (stall_edge) begin
                state         <= STALL;
                slot_ex       <= '0;
                FOperandA_OUT <= '0;
                FOperandB_OUT <= '0;
                Forward_OUT   <= 1'b0;
            end else begin
                state         <= RUN;
                slot_ex       <= slot_id;
                FOperandA_OUT <= op_a;
                FOperandB_OUT <= op_b;
                Forward_OUT   <= (sel_a != SRC_RF) || (sel_b != SRC_RF);
            end
        end
    end

endmodule
